// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce controller: FSM state encoding,
// default timing parameters and small state-decoding helpers.
package debounce_pkg;

  localparam int DEF_TICK_DIV   = 50000;
  localparam int DEF_STABLE_CNT = 10;

  typedef enum logic [1:0] {
    ST_LOW    = 2'd0,
    ST_WAIT_H = 2'd1,
    ST_HIGH   = 2'd2,
    ST_WAIT_L = 2'd3
  } state_t;

  function automatic logic is_wait(state_t s);
    return (s == ST_WAIT_H) || (s == ST_WAIT_L);
  endfunction

  // WAIT_L still reports the old high level until the fall is committed.
  function automatic logic level_of(state_t s);
    return (s == ST_HIGH) || (s == ST_WAIT_L);
  endfunction

endpackage

// File: rtl/debounce_ctrl_if.sv
// Board-side input and user-side debounced outputs of the debounce controller.
interface debounce_ctrl_if;

  logic din;
  logic db_out;
  logic rise_pulse;
  logic fall_pulse;
  logic busy;

  modport slave (
    input  din,
    output db_out,
    output rise_pulse,
    output fall_pulse,
    output busy
  );

  modport master (
    output din,
    input  db_out,
    input  rise_pulse,
    input  fall_pulse,
    input  busy
  );

endinterface

// File: rtl/bit_stable_det.sv
// Remembers the synchronised input at each enable and reports whether the
// current value agrees with the previous sample.
module bit_stable_det (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic din_s,
  output logic same,
  output logic samp
);

  logic samp_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_prev <= 1'b0;
    end else if (en) begin
      samp_prev <= din_s;
    end
  end

  assign same = ~(samp_prev ^ din_s);
  assign samp = samp_prev;

endmodule

// File: rtl/debounce_ctrl.sv
// Debounces one noisy board input: synchronise, sample on a prescaled tick,
// and commit a new level only after STABLE_CNT agreeing samples.
module debounce_ctrl
  import debounce_pkg::*;
#(
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int STABLE_CNT = DEF_STABLE_CNT
) (
  input logic            clk,
  input logic            rst,
  debounce_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int SC_W  = $clog2(STABLE_CNT + 1);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [SC_W-1:0]  CNT_LAST  = SC_W'(STABLE_CNT - 1);

  logic [1:0]       sync_q;
  logic             din_s;
  logic [CNT_W-1:0] pcnt;
  logic             tick;
  logic             same;
  logic             samp;
  logic [SC_W-1:0]  cnt, cnt_n;
  state_t           state, state_n;
  logic             db_q, rise_q, fall_q, busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], bus.din};
    end
  end

  assign din_s = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  assign tick = (pcnt == TICK_LAST);

  bit_stable_det u_det (
    .clk   (clk),
    .rst   (rst),
    .en    (tick),
    .din_s (din_s),
    .same  (same),
    .samp  (samp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_LOW;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Inside a WAIT state the previous sample always holds the candidate level,
  // so "same as last sample" with that level means another agreeing tick.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (tick) begin
      case (state)
        ST_LOW: begin
          if (din_s) begin
            state_n = ST_WAIT_H;
            cnt_n   = SC_W'(1);
          end
        end
        ST_WAIT_H: begin
          if (same && samp) begin
            if (cnt == CNT_LAST) begin
              state_n = ST_HIGH;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end else begin
            state_n = ST_LOW;
            cnt_n   = '0;
          end
        end
        ST_HIGH: begin
          if (!din_s) begin
            state_n = ST_WAIT_L;
            cnt_n   = SC_W'(1);
          end
        end
        ST_WAIT_L: begin
          if (same && !samp) begin
            if (cnt == CNT_LAST) begin
              state_n = ST_LOW;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end else begin
            state_n = ST_HIGH;
            cnt_n   = '0;
          end
        end
        default: begin
          state_n = ST_LOW;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the state flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      db_q   <= level_of(state_n);
      rise_q <= (state == ST_WAIT_H) && (state_n == ST_HIGH);
      fall_q <= (state == ST_WAIT_L) && (state_n == ST_LOW);
      busy_q <= is_wait(state_n);
    end
  end

  assign bus.db_out     = db_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
  assign bus.busy       = busy_q;

endmodule
